// File: rtl/data_mem_access_ctrl_pkg.sv
// Shared definitions for the EX/MEM data-memory access controller:
// FSM state encoding and default bus widths.
package data_mem_access_ctrl_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/data_mem_access_ctrl_if.sv
// Data-memory req/ack bus. master = access controller, slave = memory.
// Ports: mem_req/mem_we/mem_addr/mem_wdata (to memory), mem_ack/mem_rdata (from memory).
interface data_mem_access_ctrl_if
   import data_mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/mem_timeout_counter.sv
// Counts REQ cycles without an ack; expired marks the last allowed wait cycle.
// Ports: clk, rst, clr (wins over en), en, expired.
module mem_timeout_counter #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TO_W-1:0] count;

   assign expired = (count == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Services the EX/MEM load/store over a req/ack memory bus and owns MemStall.
// Ports: clk, rst, EXMEM_* (access request), MemStall/MEM_ReadData/MemDone/MemErr, mem (bus master).
module data_mem_access_ctrl
   import data_mem_access_ctrl_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              EXMEM_MemRead,
   input  logic              EXMEM_MemWrite,
   input  logic [ADDR_W-1:0] EXMEM_Addr,
   input  logic [DATA_W-1:0] EXMEM_WriteData,
   output logic              MemStall,
   output logic [DATA_W-1:0] MEM_ReadData,
   output logic              MemDone,
   output logic              MemErr,
   data_mem_access_ctrl_if.master mem
);

   state_t state, state_nx;
   logic   acc;
   logic   tmo_exp;
   logic   tmo_clr;
   logic   in_req;

   assign acc    = EXMEM_MemRead | EXMEM_MemWrite;
   assign in_req = (state == ST_REQ);
   // Clearing on ack/expiry resets the count on the edge that leaves REQ.
   assign tmo_clr = !in_req || mem.mem_ack || tmo_exp;

   mem_timeout_counter #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmo_clr),
      .en      (in_req),
      .expired (tmo_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      MemStall = 1'b0;
      unique case (state)
         ST_IDLE: begin
            MemStall = acc;
            if (acc) state_nx = ST_REQ;
         end
         ST_REQ: begin
            MemStall = 1'b1;
            if (mem.mem_ack || tmo_exp) state_nx = ST_DONE;
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         MEM_ReadData  <= '0;
         MemDone       <= 1'b0;
         MemErr        <= 1'b0;
      end else begin
         MemDone <= 1'b0;
         MemErr  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               // Read+write together resolves to a write.
               if (acc) begin
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= EXMEM_MemWrite;
                  mem.mem_addr  <= EXMEM_Addr;
                  mem.mem_wdata <= EXMEM_WriteData;
               end
            end
            ST_REQ: begin
               if (mem.mem_ack) begin
                  mem.mem_req <= 1'b0;
                  if (!mem.mem_we) MEM_ReadData <= mem.mem_rdata;
                  MemDone <= 1'b1;
               end else if (tmo_exp) begin
                  mem.mem_req <= 1'b0;
                  if (!mem.mem_we) MEM_ReadData <= '0;
                  MemDone <= 1'b1;
                  MemErr  <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Randomised + directed bench for data_mem_access_ctrl against a transaction model.
// Ports: none (top-level bench).
module tb_data_mem_access_ctrl;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        EXMEM_MemRead;
   logic        EXMEM_MemWrite;
   logic [31:0] EXMEM_Addr;
   logic [31:0] EXMEM_WriteData;
   logic        MemStall;
   logic [31:0] MEM_ReadData;
   logic        MemDone;
   logic        MemErr;

   data_mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   data_mem_access_ctrl #(
      .DATA_W  (32),
      .ADDR_W  (32),
      .TIMEOUT (TMO),
      .TO_W    (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .EXMEM_MemRead   (EXMEM_MemRead),
      .EXMEM_MemWrite  (EXMEM_MemWrite),
      .EXMEM_Addr      (EXMEM_Addr),
      .EXMEM_WriteData (EXMEM_WriteData),
      .MemStall        (MemStall),
      .MEM_ReadData    (MEM_ReadData),
      .MemDone         (MemDone),
      .MemErr          (MemErr),
      .mem             (bus.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // transaction-level model
   bit          m_busy;
   bit          m_done;
   bit          m_err;
   bit          m_we;
   int          m_wait;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rd;

   // DUT samples from the most recent cycle
   logic        s_stall, s_req, s_we, s_done, s_err;
   logic [31:0] s_addr, s_wdata, s_rd;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 0;
      m_done  = 0;
      m_err   = 0;
      m_we    = 0;
      m_wait  = 0;
      m_addr  = '0;
      m_wdata = '0;
      m_rd    = '0;
   endtask

   task automatic compare();
      logic exp_stall;
      if (m_busy)      exp_stall = 1'b1;
      else if (m_done) exp_stall = 1'b0;
      else             exp_stall = EXMEM_MemRead | EXMEM_MemWrite;
      s_stall = MemStall;
      s_req   = bus.mem_req;
      s_we    = bus.mem_we;
      s_addr  = bus.mem_addr;
      s_wdata = bus.mem_wdata;
      s_done  = MemDone;
      s_err   = MemErr;
      s_rd    = MEM_ReadData;
      chk("stall", 32'(s_stall), 32'(exp_stall));
      chk("req",   32'(s_req),   32'(m_busy));
      chk("done",  32'(s_done),  32'(m_done));
      chk("err",   32'(s_err),   32'(m_err));
      chk("we",    32'(s_we),    32'(m_we));
      chk("addr",  s_addr,  m_addr);
      chk("wdata", s_wdata, m_wdata);
      chk("rdata", s_rd,    m_rd);
   endtask

   task automatic step();
      if (rst) begin
         model_reset();
      end else if (m_busy) begin
         if (bus.mem_ack) begin
            m_busy = 0;
            m_done = 1;
            m_err  = 0;
            if (!m_we) m_rd = bus.mem_rdata;
         end else if (m_wait == TMO - 1) begin
            m_busy = 0;
            m_done = 1;
            m_err  = 1;
            if (!m_we) m_rd = '0;
         end else begin
            m_wait++;
         end
      end else if (m_done) begin
         m_done = 0;
         m_err  = 0;
      end else if (EXMEM_MemRead | EXMEM_MemWrite) begin
         m_busy  = 1;
         m_wait  = 0;
         m_we    = EXMEM_MemWrite;
         m_addr  = EXMEM_Addr;
         m_wdata = EXMEM_WriteData;
      end
   endtask

   task automatic cyc(input logic r, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic ack, input logic [31:0] rdat);
      rst             = r;
      EXMEM_MemRead   = rd;
      EXMEM_MemWrite  = wr;
      EXMEM_Addr      = a;
      EXMEM_WriteData = wd;
      bus.mem_ack     = ack;
      bus.mem_rdata   = rdat;
      @(negedge clk);
      compare();
      step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ack_pct;
      model_reset();
      rst = 1'b1;
      EXMEM_MemRead = 0;
      EXMEM_MemWrite = 0;
      EXMEM_Addr = '0;
      EXMEM_WriteData = '0;
      bus.mem_ack = 0;
      bus.mem_rdata = '0;
      @(posedge clk);
      #1;
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);

      // reset values
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("rst_req", 32'(s_req), 0);
      chk("rst_stall", 32'(s_stall), 0);
      chk("rst_rd", s_rd, 0);

      // load, immediate ack
      cyc(0, 1, 0, 32'h10, 0, 0, 0);
      chk("ld_stall1", 32'(s_stall), 1);
      cyc(0, 1, 0, 32'h10, 0, 1, 32'hDEADBEEF);
      chk("ld_stall2", 32'(s_stall), 1);
      chk("ld_addr", s_addr, 32'h10);
      chk("ld_we", 32'(s_we), 0);
      cyc(0, 1, 0, 32'h10, 0, 0, 0);
      chk("ld_stall3", 32'(s_stall), 0);
      chk("ld_done", 32'(s_done), 1);
      chk("ld_data", s_rd, 32'hDEADBEEF);

      // store, ack in third REQ cycle
      cyc(0, 0, 1, 32'h20, 32'h12345678, 0, 0);
      cyc(0, 0, 1, 32'h20, 32'h12345678, 0, 0);
      chk("st_req1", 32'(s_req), 1);
      cyc(0, 0, 1, 32'h20, 32'h12345678, 0, 0);
      chk("st_wdata", s_wdata, 32'h12345678);
      cyc(0, 0, 1, 32'h20, 32'h12345678, 1, 32'h0BAD0BAD);
      chk("st_we", 32'(s_we), 1);
      chk("st_stall4", 32'(s_stall), 1);
      cyc(0, 0, 1, 32'h20, 32'h12345678, 0, 0);
      chk("st_done", 32'(s_done), 1);
      chk("st_rd_kept", s_rd, 32'hDEADBEEF);

      // timeout
      cyc(0, 1, 0, 32'h30, 0, 0, 0);
      for (int i = 0; i < TMO; i++) begin
         cyc(0, 1, 0, 32'h30, 0, 0, 0);
         chk("to_req", 32'(s_req), 1);
      end
      cyc(0, 1, 0, 32'h30, 0, 0, 0);
      chk("to_done", 32'(s_done), 1);
      chk("to_err", 32'(s_err), 1);
      chk("to_rd", s_rd, 0);
      chk("to_req0", 32'(s_req), 0);

      // back-to-back load then store
      cyc(0, 1, 0, 32'h40, 0, 0, 0);
      cyc(0, 1, 0, 32'h40, 0, 1, 32'hA5A5A5A5);
      cyc(0, 1, 0, 32'h40, 0, 0, 0);
      chk("bb_done", 32'(s_done), 1);
      chk("bb_stall_done", 32'(s_stall), 0);
      cyc(0, 0, 1, 32'h44, 32'h55, 0, 0);
      chk("bb_stall_idle", 32'(s_stall), 1);
      chk("bb_err", 32'(s_err), 0);
      cyc(0, 0, 1, 32'h44, 32'h55, 1, 0);
      chk("bb_req2", 32'(s_req), 1);
      chk("bb_addr2", s_addr, 32'h44);
      cyc(0, 0, 0, 0, 0, 0, 0);

      // reset mid-REQ, then late ack
      cyc(0, 1, 0, 32'h50, 0, 0, 0);
      cyc(0, 1, 0, 32'h50, 0, 0, 0);
      chk("mr_req", 32'(s_req), 1);
      cyc(1, 1, 0, 32'h50, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'h77);
      chk("mr_req0", 32'(s_req), 0);
      chk("mr_addr0", s_addr, 0);
      chk("mr_done", 32'(s_done), 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("mr_done2", 32'(s_done), 0);
      chk("mr_rd", s_rd, 0);

      // idle, then read+write together
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 32'h99, 0, 1, 32'h1);
         chk("idle_stall", 32'(s_stall), 0);
      end
      cyc(0, 1, 1, 32'h60, 32'hCAFE, 0, 0);
      cyc(0, 1, 1, 32'h60, 32'hCAFE, 1, 32'h3333);
      chk("rw_we", 32'(s_we), 1);
      cyc(0, 1, 1, 32'h60, 32'hCAFE, 0, 0);
      chk("rw_rd", s_rd, 0);

      // randomised traffic
      for (int blk = 0; blk < 16; blk++) begin
         unique case (blk % 4)
            0: ack_pct = 50;
            1: ack_pct = 0;
            2: ack_pct = 15;
            default: ack_pct = 90;
         endcase
         for (int i = 0; i < 200; i++) begin
            cyc($urandom_range(0, 49) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom, $urandom,
                $urandom_range(0, 99) < ack_pct,
                $urandom);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
